input_filter_ctrl: RTL
======================

Name: input_filter_ctrl

Overview:
Multi-channel input conditioning controller for slow 3.3 V digital lines, such as SPI and GPIO from external microcontrollers. It synchronizes each raw line and samples all lines on a shared programmable prescaler tick. A line's filtered level updates only after a configurable number of consecutive equal samples. Level changes are reported as rise/fall events through a single valid/ready port, with round-robin arbitration across channels. The block sits between board pins and the SPI/command logic and replaces ad-hoc per-line deglitch registers.

Parameters:
NCHAN, 4, number of input channels (1..16)
CNTW, 4, width of per-channel stability counter and cfg_depth
PRESCW, 16, width of sample prescaler and cfg_prescale

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
raw  input  NCHAN  unsynchronized input lines
cfg_enable  input  NCHAN  per-channel filter enable
cfg_prescale  input  PRESCW  sample tick every cfg_prescale+1 clocks
cfg_depth  input  CNTW  consecutive equal samples required to commit; 0 treated as 1
level  output  NCHAN  filtered levels
evt_valid  output  1  event available
evt_chan  output  max(1,clog2(NCHAN))  channel of event
evt_rise  output  1  1 = rising, 0 = falling
evt_ready  input  1  consumer accepts event
overflow  output  NCHAN  sticky: channel committed again while its event was still pending
overflow_clr  input  1  clears all overflow bits (set has priority in the same cycle)

Behaviour:
- One clock domain. Reset is asynchronous and active-low (reset_n).
- Reset values: level=0, evt_valid=0, evt_chan=0, evt_rise=0, overflow=0.
  - Internal state resets to: sync flops 0, candidates 0, counters 0, pending 0, prescaler 0, round-robin pointer so channel 0 has first priority.
- Synchronizer: 2 flops per channel; sync = second flop.
- Prescaler:
  - Counts 0..cfg_prescale; tick asserts on the cycle count==cfg_prescale, then the counter returns to 0.
  - cfg_prescale=0 gives a tick every cycle.
  - A cfg_prescale change takes effect at the latest after the next wrap; a count above the new value wraps at the all-ones maximum.
- On each tick, for each enabled channel:
  - newcnt = 1 if sync != cand, else min(cnt+1, 2^CNTW-1).
  - cand <= sync; cnt <= newcnt.
  - If newcnt >= depth_eff and sync != level: commit.
- Commit:
  - level[ch] <= sync.
  - pending[ch] <= 1; pdir[ch] <= sync.
  - If pending[ch] was already 1 and is not being issued this cycle: overflow[ch] <= 1, and pdir is overwritten with the latest direction (one event, newest direction).
- Disabled channel:
  - cnt <= 0, cand <= sync, pending[ch] <= 0; level[ch] holds.
  - A pending event not yet issued is dropped; an already-issued event is unaffected.
- Event output (registered):
  - When evt_valid=0, or evt_valid && evt_ready, select the first pending channel at or after pointer+1 (round-robin).
  - Load evt_chan/evt_rise, set evt_valid, clear that pending bit, pointer <= selected channel.
  - If no channel is pending, evt_valid <= 0.
- Handshake:
  - evt_chan/evt_rise stay stable while evt_valid && !evt_ready.
  - Back-to-back events are issued on consecutive cycles when evt_ready is held high.
- Same-cycle events:
  - Issue and new commit on the same channel: the old event is issued, pending stays 1 with the new direction, no overflow.
  - Multiple channels committing in one tick: all set pending; issue order follows round-robin.
- Latency: commit-to-evt_valid is 1 cycle.
  - With prescale=0, a raw step appears on level exactly depth_eff+2 clocks after the first capturing edge.
- depth change mid-count: compared at the next tick (>=), so lowering depth may commit immediately.
- Reset mid-operation: all outputs clear asynchronously; any pending or in-flight event is lost.

Test Plan:
- prescale=0, depth=3, enable=1: raw[0] 0->1 before edge 1 -> level[0]=1 after edge 5; evt_valid=1, evt_chan=0, evt_rise=1 after edge 6; evt_ready=1 clears it next cycle.
- depth=3: raw[1] high for exactly 2 clocks -> level[1] stays 0, no event. Same with depth=0 (treated as 1): level[1]=1 3 clocks after the edge, then returns to 0 after the pulse, giving rise then fall events.
- evt_ready=0; ch0 and ch2 commit in the same tick -> evt_chan=0 held stable for 10 cycles. Raise evt_ready -> next cycle evt_chan=2, then evt_valid=0. A subsequent ch0+ch3 commit issues ch3 before ch0.
- evt_ready=0 with a ch3 event queued behind ch0; ch1 rises then falls before issue -> overflow[1]=1, exactly one ch1 event with evt_rise=0. Pulse overflow_clr -> overflow=0.
- prescale=9, depth=2: raw[2] step -> level[2] changes between 12 and 22 clocks later, only on tick cycles. cfg_enable[2]=0 during a pending event -> event never issued and level holds.
- Assert reset_n=0 mid-cycle with evt_valid=1 and level=4'b1011 -> level, evt_valid and overflow go 0 without a clock edge. After release, the first event comes from channel 0 priority.

Source files
------------

// File: rtl/input_filter_ctrl.sv
// Multi-channel input deglitcher: 2-flop sync, prescaled sampling, N-equal-sample commit,
// and a round-robin arbitrated rise/fall event port with sticky per-channel overflow.
module input_filter_ctrl #(
    parameter int NCHAN  = 4,
    parameter int CNTW   = 4,
    parameter int PRESCW = 16,
    localparam int CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NCHAN-1:0]  raw,
    input  logic [NCHAN-1:0]  cfg_enable,
    input  logic [PRESCW-1:0] cfg_prescale,
    input  logic [CNTW-1:0]   cfg_depth,
    output logic [NCHAN-1:0]  level,
    output logic              evt_valid,
    output logic [CHW-1:0]    evt_chan,
    output logic              evt_rise,
    input  logic              evt_ready,
    output logic [NCHAN-1:0]  overflow,
    input  logic              overflow_clr
);

    logic [NCHAN-1:0]  sync_a, sync_b;
    logic [NCHAN-1:0]  cand, pending, pdir;
    logic [CNTW-1:0]   cnt [NCHAN];
    logic [CNTW-1:0]   newcnt [NCHAN];
    logic [NCHAN-1:0]  commit, issue_mask, ovf_set, eligible;
    logic [PRESCW-1:0] presc_cnt;
    logic [CNTW-1:0]   depth_eff;
    logic [CHW-1:0]    ptr, sel_chan;
    logic              tick, can_issue, sel_found, issue;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Counter wraps at all-ones too, so a prescale lowered below the current count still recovers.
    assign tick = (presc_cnt == cfg_prescale);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            presc_cnt <= '0;
        else if (tick || (presc_cnt == '1))
            presc_cnt <= '0;
        else
            presc_cnt <= presc_cnt + PRESCW'(1);
    end

    assign depth_eff = (cfg_depth == '0) ? CNTW'(1) : cfg_depth;

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            if (sync_b[c] != cand[c])
                newcnt[c] = CNTW'(1);
            else if (cnt[c] == '1)
                newcnt[c] = cnt[c];
            else
                newcnt[c] = cnt[c] + CNTW'(1);
            commit[c] = tick && cfg_enable[c] && (newcnt[c] >= depth_eff) && (sync_b[c] != level[c]);
        end
    end

    // Disabled channels are excluded so a dropped event cannot be issued in its last cycle.
    assign eligible  = pending & cfg_enable;
    assign can_issue = !evt_valid || evt_ready;

    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_chan  = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            idx = (int'(ptr) + i) % NCHAN;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_chan  = CHW'(idx);
            end
        end
    end

    assign issue      = can_issue && sel_found;
    assign issue_mask = issue ? (NCHAN'(1) << sel_chan) : '0;
    assign ovf_set    = commit & pending & ~issue_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cand    <= '0;
            pending <= '0;
            pdir    <= '0;
            level   <= '0;
            for (int c = 0; c < NCHAN; c++)
                cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (!cfg_enable[c]) begin
                    cnt[c]     <= '0;
                    cand[c]    <= sync_b[c];
                    pending[c] <= 1'b0;
                end else begin
                    if (tick) begin
                        cand[c] <= sync_b[c];
                        cnt[c]  <= newcnt[c];
                    end
                    // A fresh commit wins over the issue clear: old event leaves, new one stays queued.
                    if (commit[c]) begin
                        level[c]   <= sync_b[c];
                        pending[c] <= 1'b1;
                        pdir[c]    <= sync_b[c];
                    end else if (issue_mask[c]) begin
                        pending[c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            overflow <= '0;
        else
            overflow <= (overflow & ~{NCHAN{overflow_clr}}) | ovf_set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            evt_rise  <= 1'b0;
            ptr       <= CHW'(NCHAN - 1);
        end else if (can_issue) begin
            if (sel_found) begin
                evt_valid <= 1'b1;
                evt_chan  <= sel_chan;
                evt_rise  <= pdir[sel_chan];
                ptr       <= sel_chan;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
